// File: rtl/exe_stage_pkg.sv
// -----------------------------------------------------------------------------
// exe_stage_pkg
// Shared definitions for the execute stage: bus widths, the field layout of the
// decode->execute and execute->memory bundles, and the one-hot alu_op bit
// indices.
// -----------------------------------------------------------------------------
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 150;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ALU_OP_WD       = 12;

    // alu_op one-hot bit indices
    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SLT   = 2;
    localparam int OP_SLTU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_NOR   = 5;
    localparam int OP_OR    = 6;
    localparam int OP_XOR   = 7;
    localparam int OP_SLL   = 8;
    localparam int OP_SRL   = 9;
    localparam int OP_SRA   = 10;
    localparam int OP_LUI   = 11;

    // Field order matches the bus bit positions, MSB first.
    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;       // [149:138]
        logic                 res_from_mem; // [137]
        logic                 src1_is_pc;   // [136]
        logic                 src2_is_imm;  // [135]
        logic                 gr_we;        // [134]
        logic                 mem_we;       // [133]
        logic [4:0]           dest;         // [132:128]
        logic [31:0]          imm;          // [127:96]
        logic [31:0]          rj_value;     // [95:64]
        logic [31:0]          rkd_value;    // [63:32]
        logic [31:0]          pc;           // [31:0]
    } ds_bus_t;

    typedef struct packed {
        logic        res_from_mem; // [70]
        logic        gr_we;        // [69]
        logic [4:0]  dest;         // [68:64]
        logic [31:0] alu_result;   // [63:32]
        logic [31:0] pc;           // [31:0]
    } es_bus_t;

endpackage

// File: rtl/exe_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU driven by a one-hot alu_op.
//   alu_op     in  12  one-hot operation select (all-zero -> result 0)
//   src1       in  32  first operand
//   src2       in  32  second operand (shift amount is src2[4:0])
//   alu_result out 32  result
// -----------------------------------------------------------------------------
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [31:0]          src1,
    input  logic [31:0]          src2,
    output logic [31:0]          alu_result
);

    logic [31:0] add_sub_res;
    logic [31:0] sub_res;
    logic [4:0]  sa;

    assign add_sub_res = src1 + src2;
    assign sub_res     = src1 - src2;
    assign sa          = src2[4:0];

    // AND-OR mux: with a one-hot select each term is gated by its own bit, so
    // an all-zero select naturally yields 0.
    always_comb begin
        alu_result = '0;
        alu_result |= {32{alu_op[OP_ADD]}}  & add_sub_res;
        alu_result |= {32{alu_op[OP_SUB]}}  & sub_res;
        alu_result |= {32{alu_op[OP_SLT]}}  & {31'd0, ($signed(src1) < $signed(src2))};
        alu_result |= {32{alu_op[OP_SLTU]}} & {31'd0, (src1 < src2)};
        alu_result |= {32{alu_op[OP_AND]}}  & (src1 & src2);
        alu_result |= {32{alu_op[OP_NOR]}}  & ~(src1 | src2);
        alu_result |= {32{alu_op[OP_OR]}}   & (src1 | src2);
        alu_result |= {32{alu_op[OP_XOR]}}  & (src1 ^ src2);
        alu_result |= {32{alu_op[OP_SLL]}}  & (src1 << sa);
        alu_result |= {32{alu_op[OP_SRL]}}  & (src1 >> sa);
        alu_result |= {32{alu_op[OP_SRA]}}  & 32'($signed(src1) >>> sa);
        alu_result |= {32{alu_op[OP_LUI]}}  & src2;
    end

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage: latches the decoded bundle under valid/allowin, computes the
// ALU result, issues the data-SRAM request and publishes its destination
// register for hazard detection.
//   clk, reset                     clock, synchronous active-high reset
//   ms_allowin      in   1         memory stage can accept
//   es_allowin      out  1         execute can accept from decode
//   ds_to_es_valid  in   1         decode offers a bundle
//   ds_to_es_bus    in   150       decoded bundle
//   es_to_ms_valid  out  1         bundle offered to memory
//   es_to_ms_bus    out  71        {res_from_mem, gr_we, dest, alu_result, pc}
//   es_dest         out  5         pending write destination (0 = none)
//   data_sram_*     out            data SRAM request
// All outputs depend only on the stage registers and ms_allowin.
// -----------------------------------------------------------------------------
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [4:0]                 es_dest,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    localparam logic ES_READY_GO = 1'b1;

    ds_bus_t     bundle_q, bundle_d;
    logic        es_valid_q, es_valid_d;
    logic [31:0] src1, src2, alu_result;
    es_bus_t     out_bus;

    assign es_allowin = !es_valid_q || (ES_READY_GO && ms_allowin);

    always_comb begin
        es_valid_d = es_valid_q;
        bundle_d   = bundle_q;
        if (es_allowin) begin
            es_valid_d = ds_to_es_valid;
            if (ds_to_es_valid) begin
                bundle_d = ds_bus_t'(ds_to_es_bus);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            bundle_q   <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bundle_q   <= bundle_d;
        end
    end

    assign src1 = bundle_q.src1_is_pc  ? bundle_q.pc  : bundle_q.rj_value;
    assign src2 = bundle_q.src2_is_imm ? bundle_q.imm : bundle_q.rkd_value;

    alu u_alu (
        .alu_op     (bundle_q.alu_op),
        .src1       (src1),
        .src2       (src2),
        .alu_result (alu_result)
    );

    assign es_to_ms_valid = es_valid_q && ES_READY_GO;

    always_comb begin
        out_bus.res_from_mem = bundle_q.res_from_mem;
        out_bus.gr_we        = bundle_q.gr_we;
        out_bus.dest         = bundle_q.dest;
        out_bus.alu_result   = alu_result;
        out_bus.pc           = bundle_q.pc;
    end
    assign es_to_ms_bus = out_bus;

    assign es_dest = (es_valid_q && bundle_q.gr_we) ? bundle_q.dest : 5'd0;

    // The write strobe is qualified by ms_allowin so a stalled store is only
    // written on the cycle it actually leaves for memory.
    assign data_sram_en    = es_valid_q && (bundle_q.res_from_mem || bundle_q.mem_we);
    assign data_sram_we    = {4{es_valid_q && bundle_q.mem_we && ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = bundle_q.rkd_value;

endmodule
